// File: rtl/mv_mul_nxn_fp32_stream.sv
// Streaming NxN FP32 matrix-vector multiplier with a shadow/active matrix pair,
// a non-stalling multiply/add-tree pipeline and a credit-protected output FIFO.
`timescale 1ns/1ps
module mv_mul_nxn_fp32_stream #(
  parameter int N     = 4,
  parameter int IDW   = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [$clog2(N*N)-1:0] cfg_addr,
  input  logic [31:0]            cfg_data,
  input  logic                   cfg_commit,
  output logic                   cfg_busy,
  input  logic                   mode_affine,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IDW-1:0]         in_id,
  input  logic [N*32-1:0]        in_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDW-1:0]         out_id,
  output logic [N*32-1:0]        out_vec,
  output logic                   out_ovf
);

  localparam int LG    = $clog2(N);
  // Stages: S0, S1 (products), LG adder levels, write-back register.
  localparam int NST   = LG + 3;
  localparam int NODES = 2 * N - 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam int FW    = 1 + IDW + N * 32;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  // {overflow, result}; subnormals flush to zero, round to nearest even.
  function automatic logic [32:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              sgn;
    logic [47:0]       p;
    logic [23:0]       sig;
    logic [24:0]       rnd;
    logic              g;
    logic              s;
    logic signed [9:0] e;
    logic [32:0]       res;
    sgn = a[31] ^ b[31];
    p   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e   = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      sig = p[47:24];
      g   = p[23];
      s   = |p[22:0];
      e   = e + 10'sd1;
    end else begin
      sig = p[46:23];
      g   = p[22];
      s   = |p[21:0];
    end
    rnd = {1'b0, sig} + {24'd0, g & (s | sig[0])};
    if (rnd[24]) begin
      sig = rnd[24:1];
      e   = e + 10'sd1;
    end else begin
      sig = rnd[23:0];
    end
    res = {1'b0, sgn, e[7:0], sig[22:0]};
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
          a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
        res = {1'b0, QNAN};
      end else begin
        res = {1'b0, sgn, 8'hFF, 23'd0};
      end
    end else if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
      res = {1'b0, sgn, 31'd0};
    end else if (e >= 10'sd255) begin
      res = {1'b1, sgn, 8'hFF, 23'd0};
    end else if (e <= 10'sd0) begin
      res = {1'b0, sgn, 31'd0};
    end
    return res;
  endfunction

  function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x;
    logic [31:0]       y;
    logic [7:0]        ex;
    logic [7:0]        ey;
    logic [7:0]        d;
    logic [26:0]       mx;
    logic [26:0]       my;
    logic [26:0]       sh;
    logic [26:0]       lost;
    logic [27:0]       sum;
    logic [23:0]       sig;
    logic [24:0]       rnd;
    logic signed [9:0] e;
    logic [32:0]       res;
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    ex = x[30:23];
    ey = y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = (ey == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
    d  = ex - ey;
    lost = 27'd0;
    if (d >= 8'd27) begin
      sh = {26'd0, |my};
    end else begin
      lost = my & ((27'd1 << d) - 27'd1);
      sh   = (my >> d) | {26'd0, |lost};
    end
    if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, sh};
    else                sum = {1'b0, mx} - {1'b0, sh};
    e = $signed({2'b00, ex});
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e   = e + 10'sd1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!sum[26] && sum != 28'd0) begin
        sum = sum << 1;
        e   = e - 10'sd1;
      end
    end
    sig = sum[26:3];
    rnd = {1'b0, sig} + {24'd0, sum[2] & ((|sum[1:0]) | sig[0])};
    if (rnd[24]) begin
      sig = rnd[24:1];
      e   = e + 10'sd1;
    end else begin
      sig = rnd[23:0];
    end
    res = {1'b0, x[31], e[7:0], sig[22:0]};
    if (ex == 8'hFF) begin
      // x holds the larger magnitude, so any Inf/NaN operand lands here.
      if (x[22:0] != 23'd0 || (ey == 8'hFF && x[31] != y[31])) res = {1'b0, QNAN};
      else                                                      res = {1'b0, x};
    end else if (ex == 8'd0 || sum == 28'd0) begin
      res = {1'b0, x[31] & y[31], 31'd0};
    end else if (e >= 10'sd255) begin
      res = {1'b1, x[31], 8'hFF, 23'd0};
    end else if (e <= 10'sd0) begin
      res = {1'b0, x[31], 31'd0};
    end
    return res;
  endfunction

  logic [31:0]    shadow_q [N*N];
  logic [31:0]    shadow_d [N*N];
  logic [31:0]    active_q [N*N];
  logic [31:0]    active_d [N*N];
  logic           busy_q, busy_d;
  logic [NST-1:0] vld_q, vld_d;
  logic [NST-1:0] ovf_q, ovf_d;
  logic [IDW-1:0] id_q [NST];
  logic [IDW-1:0] id_d [NST];
  logic [N*32-1:0] s0_vec_q, s0_vec_d;
  logic [N*32-1:0] wb_vec_q, wb_vec_d;
  logic [31:0]    node_q [N][NODES];
  logic [31:0]    node_d [N][NODES];
  logic [FW-1:0]  mem_q [DEPTH];
  logic [FW-1:0]  mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d, inflight_q, inflight_d;
  logic           acc, push, pop;
  logic [FW-1:0]  rd_word;

  // Credits cover both queued and in-flight vertices, so the pipeline never has to stall.
  assign in_ready  = (({1'b0, cnt_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH)) && !busy_q;
  assign acc       = in_valid && in_ready;
  assign push      = vld_q[NST-1];
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign cfg_busy  = busy_q;
  assign rd_word   = mem_q[rd_ptr_q];
  assign out_vec   = out_valid ? rd_word[N*32-1:0] : '0;
  assign out_id    = out_valid ? rd_word[N*32 +: IDW] : '0;
  assign out_ovf   = out_valid && rd_word[FW-1];

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    busy_d   = busy_q;
    if (cfg_we && !busy_q) shadow_d[cfg_addr] = cfg_data;
    if (!busy_q) begin
      if (cfg_commit) busy_d = 1'b1;
    end else if (inflight_q == '0) begin
      busy_d   = 1'b0;
      active_d = shadow_q;
    end
  end

  always_comb begin : p_pipe
    logic [32:0] t;
    logic        flags;
    int          lo;
    int          li;
    t     = '0;
    flags = 1'b0;
    lo    = 0;
    li    = 0;
    s0_vec_d = in_vec;
    if (mode_affine) s0_vec_d[32*(N-1) +: 32] = ONE;
    vld_d   = {vld_q[NST-2:0], acc};
    id_d[0] = in_id;
    for (int s = 1; s < NST; s++) id_d[s] = id_q[s-1];
    node_d = node_q;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        t = fp_mul(active_q[r*N+c], s0_vec_q[32*c +: 32]);
        node_d[r][c] = t[31:0];
        flags = flags | t[32];
      end
    end
    ovf_d[0] = 1'b0;
    ovf_d[1] = ovf_q[0] | flags;
    // Level k of each row's tree lives at node offset 2N - 2N/2^k.
    for (int k = 1; k <= LG; k++) begin
      flags = 1'b0;
      lo = 2 * N - ((2 * N) >> (k - 1));
      li = 2 * N - ((2 * N) >> k);
      for (int r = 0; r < N; r++) begin
        for (int j = 0; j < (N >> k); j++) begin
          t = fp_add(node_q[r][lo+2*j], node_q[r][lo+2*j+1]);
          node_d[r][li+j] = t[31:0];
          flags = flags | t[32];
        end
      end
      ovf_d[k+1] = ovf_q[k] | flags;
    end
    ovf_d[NST-1] = ovf_q[NST-2];
    for (int r = 0; r < N; r++) wb_vec_d[32*r +: 32] = node_q[r][NODES-1];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {ovf_q[NST-1], id_q[NST-1], wb_vec_q};
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    inflight_d = inflight_q + CW'(acc) - CW'(push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      ovf_q      <= '0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < N * N; i++) begin
        shadow_q[i] <= (i % (N + 1) == 0) ? ONE : 32'd0;
        active_q[i] <= (i % (N + 1) == 0) ? ONE : 32'd0;
      end
    end else begin
      vld_q      <= vld_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  // Datapath and FIFO storage carry no reset; validity is tracked by vld_q and cnt_q.
  always_ff @(posedge clk) begin
    s0_vec_q <= s0_vec_d;
    id_q     <= id_d;
    node_q   <= node_d;
    wb_vec_q <= wb_vec_d;
    mem_q    <= mem_d;
  end

endmodule

// File: tb/tb_mv_mul_nxn_fp32_stream.sv
// Directed self-checking bench for mv_mul_nxn_fp32_stream (N=4, IDW=8, DEPTH=8).
`timescale 1ns/1ps
module tb_mv_mul_nxn_fp32_stream;

  logic         clk = 1'b0;
  logic         rst, cfg_we, cfg_commit, cfg_busy, mode_affine;
  logic [3:0]   cfg_addr;
  logic [31:0]  cfg_data;
  logic         in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [7:0]   in_id, out_id;
  logic [127:0] in_vec, out_vec;

  int ncmp = 0;
  int nfail = 0;

  localparam logic [127:0] V1234 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};

  mv_mul_nxn_fp32_stream #(.N(4), .IDW(8), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_busy   (cfg_busy),
    .mode_affine(mode_affine),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_id      (in_id),
    .in_vec     (in_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_vec    (out_vec),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic commit);
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    cfg_commit = commit;
    step();
    cfg_we = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (cfg_busy && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_busy_clear"}, cfg_busy, 0);
  endtask

  task automatic send(input logic [7:0] id, input logic [127:0] vec, input logic aff);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    in_id = id;
    in_vec = vec;
    mode_affine = aff;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    mode_affine = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] id, input logic [127:0] vec,
                            input logic ovf);
    int n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_id"}, out_id, id);
    chk({tag, "_vec"}, out_vec, vec);
    chk({tag, "_ovf"}, out_ovf, ovf);
    step();
  endtask

  function automatic logic [127:0] bp_vec(input int i);
    logic [31:0] k;
    k = i;
    return {32'h40800000 + k, 32'h40400000 + k, 32'h40000000 + k, 32'h3F800000 + k};
  endfunction

  initial begin
    int nacc;
    int n;
    logic acc;
    logic [7:0] held_id;
    logic [127:0] held_vec;
    rst = 1'b1; cfg_we = 1'b0; cfg_commit = 1'b0; mode_affine = 1'b0;
    cfg_addr = '0; cfg_data = '0; in_valid = 1'b0; in_id = '0; in_vec = '0; out_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_busy", cfg_busy, 0);

    // Identity pass-through, latency of 5 edges
    send(8'h11, V1234, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("lat_early", out_valid, 0);
    end
    step();
    chk("lat_valid", out_valid, 1);
    chk("lat_id", out_id, 8'h11);
    chk("lat_vec", out_vec, V1234);
    chk("lat_ovf", out_ovf, 0);
    step();
    chk("lat_popped", out_valid, 0);

    // Diagonal 2.0; last write shares the commit cycle; write while busy is ignored
    wr(4'd0, 32'h40000000, 1'b0);
    wr(4'd5, 32'h40000000, 1'b0);
    wr(4'd10, 32'h40000000, 1'b0);
    wr(4'd15, 32'h40000000, 1'b1);
    chk("commit_busy", cfg_busy, 1);
    wr(4'd0, 32'h41100000, 1'b0);
    wait_idle("diag2");
    send(8'h12, V1234, 1'b0);
    expect_out("diag2", 8'h12, {32'h41000000, 32'h40C00000, 32'h40800000, 32'h40000000}, 1'b0);

    // Backpressure: 12 offered, 8 accepted, drained in order
    do_reset();
    out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      in_id = 8'h20 + 8'(nacc);
      in_vec = bp_vec(nacc);
      in_valid = 1'b1;
      acc = in_ready;
      step();
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    chk("bp_accepts", nacc, 8);
    chk("bp_in_ready_low", in_ready, 0);
    repeat (6) step();
    chk("bp_valid", out_valid, 1);
    held_id = 8'h20;
    held_vec = bp_vec(0);
    step();
    chk("bp_hold_id", out_id, held_id);
    chk("bp_hold_vec", out_vec, held_vec);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_id", out_id, 8'h20 + 8'(i));
      chk("bp_drain_vec", out_vec, bp_vec(i));
      step();
    end
    chk("bp_empty", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);

    // Affine mode forces w to 1.0; without it w participates
    do_reset();
    wr(4'd3, 32'h40A00000, 1'b1);
    wait_idle("aff");
    send(8'h31, {32'h41100000, 32'h0, 32'h0, 32'h3F800000}, 1'b1);
    expect_out("aff_on", 8'h31, {32'h3F800000, 32'h0, 32'h0, 32'h40C00000}, 1'b0);
    send(8'h32, {32'h41100000, 32'h0, 32'h0, 32'h3F800000}, 1'b0);
    expect_out("aff_off", 8'h32, {32'h41100000, 32'h0, 32'h0, 32'h42380000}, 1'b0);

    // Multiplier overflow flags only the offending vertex
    do_reset();
    wr(4'd0, 32'h7F000000, 1'b1);
    wait_idle("ovf");
    send(8'h40, {32'h0, 32'h0, 32'h0, 32'h7F000000}, 1'b0);
    send(8'h41, {32'h0, 32'h0, 32'h0, 32'h3F800000}, 1'b0);
    expect_out("ovf_hit", 8'h40, {32'h0, 32'h0, 32'h0, 32'h7F800000}, 1'b1);
    expect_out("ovf_clean", 8'h41, {32'h0, 32'h0, 32'h0, 32'h7F000000}, 1'b0);

    // Reset mid-operation drops queued/in-flight work and a pending commit
    out_ready = 1'b0;
    send(8'h60, V1234, 1'b0);
    send(8'h61, V1234, 1'b0);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    do_reset();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", cfg_busy, 0);
    chk("midrst_ready", in_ready, 1);
    repeat (8) step();
    chk("midrst_no_leftover", out_valid, 0);

    // Commit with 3 vertices in flight
    wr(4'd0, 32'h40400000, 1'b0);
    wr(4'd5, 32'h40400000, 1'b0);
    wr(4'd10, 32'h40400000, 1'b0);
    wr(4'd15, 32'h40400000, 1'b0);
    send(8'h51, V1234, 1'b0);
    send(8'h52, V1234, 1'b0);
    send(8'h53, V1234, 1'b0);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
    chk("inflight_busy", cfg_busy, 1);
    chk("inflight_blocked", in_ready, 0);
    n = 0;
    while (cfg_busy && n < 50) begin
      step();
      n++;
    end
    chk("inflight_busy_cycles", n, 5);
    send(8'h54, V1234, 1'b0);
    out_ready = 1'b1;
    expect_out("old0", 8'h51, V1234, 1'b0);
    expect_out("old1", 8'h52, V1234, 1'b0);
    expect_out("old2", 8'h53, V1234, 1'b0);
    expect_out("new", 8'h54, {32'h41400000, 32'h41100000, 32'h40C00000, 32'h40400000}, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
